// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle main controller: FSM states, opcode
// classes, datapath mux selects and the decoded control bundle.
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXECR  = 4'd6,
      S_EXECI  = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9
   } state_t;

   localparam logic [1:0] OP_DP    = 2'b00;
   localparam logic [1:0] OP_MEM   = 2'b01;
   localparam logic [1:0] OP_B     = 2'b10;
   localparam logic [1:0] OP_UNDEF = 2'b11;

   localparam logic [1:0] ASRC_REG    = 2'b00;
   localparam logic [1:0] ASRC_PC     = 2'b01;
   localparam logic [1:0] ASRC_ALUOUT = 2'b10;

   localparam logic [1:0] BSRC_REG  = 2'b00;
   localparam logic [1:0] BSRC_IMM  = 2'b01;
   localparam logic [1:0] BSRC_FOUR = 2'b10;

   localparam logic [1:0] RSRC_ALUOUT = 2'b00;
   localparam logic [1:0] RSRC_DATA   = 2'b01;
   localparam logic [1:0] RSRC_ALU    = 2'b10;

   typedef struct packed {
      logic       mem_req;
      logic       ir_write;
      logic       next_pc;
      logic       reg_w;
      logic       mem_w;
      logic       branch;
      logic       alu_op;
      logic       adr_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] result_src;
      logic       illegal;
   } ctl_t;

   localparam ctl_t CTL_IDLE = '0;

endpackage

// File: rtl/mc_mainfsm_if.sv
// Controller <-> datapath/memory bundle; master is the controller, slave the datapath side.
// No flow control beyond mem_ready, which the controller waits on in memory states.
interface mc_mainfsm_if;

   logic [1:0] Op;
   logic [5:0] Funct;
   logic       mem_ready;

   logic       mem_req;
   logic       IRWrite;
   logic       NextPC;
   logic       RegW;
   logic       MemW;
   logic       Branch;
   logic       ALUOp;
   logic       AdrSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ResultSrc;
   logic       illegal;
   logic [3:0] state_o;

   modport master (
      input  Op, Funct, mem_ready,
      output mem_req, IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc,
      output ALUSrcA, ALUSrcB, ResultSrc, illegal, state_o
   );

   modport slave (
      output Op, Funct, mem_ready,
      input  mem_req, IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc,
      input  ALUSrcA, ALUSrcB, ResultSrc, illegal, state_o
   );

endinterface

// File: rtl/mc_outdec.sv
// Combinational state-to-control decode; zero latency.
// Memory-completion strobes follow ready; all strobes are forced low while run=0.
module mc_outdec
   import mc_pkg::*;
(
   input  state_t     state,
   input  logic       ready,
   input  logic       run,
   input  logic [1:0] op,
   output ctl_t       ctl
);

   ctl_t dec;

   always_comb begin
      dec = CTL_IDLE;
      case (state)
         S_FETCH: begin
            dec.mem_req    = 1'b1;
            dec.adr_src    = 1'b0;
            dec.alu_src_a  = ASRC_PC;
            dec.alu_src_b  = BSRC_FOUR;
            dec.result_src = RSRC_ALU;
            dec.ir_write   = ready;
            dec.next_pc    = ready;
         end
         S_DECODE: begin
            dec.alu_src_a  = ASRC_PC;
            dec.alu_src_b  = BSRC_FOUR;
            dec.result_src = RSRC_ALU;
            dec.illegal    = (op == OP_UNDEF);
         end
         S_MEMADR: begin
            dec.alu_src_a = ASRC_REG;
            dec.alu_src_b = BSRC_IMM;
         end
         S_EXECI: begin
            dec.alu_src_a = ASRC_REG;
            dec.alu_src_b = BSRC_IMM;
            dec.alu_op    = 1'b1;
         end
         S_EXECR: begin
            dec.alu_src_a = ASRC_REG;
            dec.alu_src_b = BSRC_REG;
            dec.alu_op    = 1'b1;
         end
         S_MEMRD: begin
            dec.mem_req    = 1'b1;
            dec.adr_src    = 1'b1;
            dec.result_src = RSRC_ALUOUT;
         end
         S_MEMWR: begin
            dec.mem_req = 1'b1;
            dec.adr_src = 1'b1;
            dec.mem_w   = ready;
         end
         S_MEMWB: begin
            dec.result_src = RSRC_DATA;
            dec.reg_w      = 1'b1;
         end
         S_ALUWB: begin
            dec.result_src = RSRC_ALUOUT;
            dec.reg_w      = 1'b1;
         end
         S_BRANCH: begin
            dec.alu_src_a  = ASRC_ALUOUT;
            dec.alu_src_b  = BSRC_IMM;
            dec.result_src = RSRC_ALU;
            dec.branch     = 1'b1;
         end
         default: ;
      endcase

      // Reset gating is combinational so strobes drop without waiting for an edge.
      ctl = dec;
      if (!run) begin
         ctl.mem_req  = 1'b0;
         ctl.ir_write = 1'b0;
         ctl.next_pc  = 1'b0;
         ctl.reg_w    = 1'b0;
         ctl.mem_w    = 1'b0;
         ctl.branch   = 1'b0;
         ctl.alu_op   = 1'b0;
         ctl.illegal  = 1'b0;
      end
   end

endmodule

// File: rtl/mc_mainfsm.sv
// Multicycle main controller FSM: B 3 cycles, DP/STR 4, LDR 5 at zero wait.
// Each cycle with mem_ready low in FETCH/MEMRD/MEMWR stretches the instruction by one.
module mc_mainfsm
   import mc_pkg::*;
#(
   parameter int MEM_WAIT_EN = 1
)
(
   input  logic          clk,
   input  logic          reset,
   mc_mainfsm_if.master  bus
);

   state_t state;
   logic   ready;
   ctl_t   ctl;
   logic   unused_funct;

   assign ready        = (MEM_WAIT_EN != 0) ? bus.mem_ready : 1'b1;
   assign unused_funct = ^bus.Funct[4:1];

   // Op/Funct are looked at only in DECODE and MEMADR.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_FETCH;
      end else begin
         case (state)
            S_FETCH:  if (ready) state <= S_DECODE;
            S_DECODE: begin
               case (bus.Op)
                  OP_MEM:  state <= S_MEMADR;
                  OP_DP:   state <= bus.Funct[5] ? S_EXECI : S_EXECR;
                  OP_B:    state <= S_BRANCH;
                  default: state <= S_FETCH;
               endcase
            end
            S_MEMADR: state <= bus.Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (ready) state <= S_MEMWB;
            S_MEMWR:  if (ready) state <= S_FETCH;
            S_EXECR,
            S_EXECI:  state <= S_ALUWB;
            S_MEMWB,
            S_ALUWB,
            S_BRANCH: state <= S_FETCH;
            default:  state <= S_FETCH;
         endcase
      end
   end

   mc_outdec u_outdec (
      .state (state),
      .ready (ready),
      .run   (reset),
      .op    (bus.Op),
      .ctl   (ctl)
   );

   assign bus.mem_req   = ctl.mem_req;
   assign bus.IRWrite   = ctl.ir_write;
   assign bus.NextPC    = ctl.next_pc;
   assign bus.RegW      = ctl.reg_w;
   assign bus.MemW      = ctl.mem_w;
   assign bus.Branch    = ctl.branch;
   assign bus.ALUOp     = ctl.alu_op;
   assign bus.AdrSrc    = ctl.adr_src;
   assign bus.ALUSrcA   = ctl.alu_src_a;
   assign bus.ALUSrcB   = ctl.alu_src_b;
   assign bus.ResultSrc = ctl.result_src;
   assign bus.illegal   = ctl.illegal;
   assign bus.state_o   = state;

endmodule

// File: doc/mc_mainfsm.md
MC_MAINFSM -- requirements
Module: mc_mainfsm

Interface
REQ-001 The block SHALL have parameter MEM_WAIT_EN, default 1, meaning 1 = honour mem_ready and 0 = treat mem_ready as constant 1.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port Op, input, 2 bits: Instr[27:26] from the instruction register.
REQ-005 The block SHALL have port Funct, input, 6 bits: Instr[25:20]; [5] = I (immediate), [0] = S/L.
REQ-006 The block SHALL have port mem_ready, input, 1 bit: the shared memory completes the current access this cycle.
REQ-007 The block SHALL have port mem_req, output, 1 bit: a memory access is requested.
REQ-008 The block SHALL have port IRWrite, output, 1 bit: load the instruction register.
REQ-009 The block SHALL have port NextPC, output, 1 bit: load the PC with PC+4.
REQ-010 The block SHALL have ports RegW, MemW and Branch, outputs, 1 bit each: unconditioned write and branch strobes, gated downstream by condition logic.
REQ-011 The block SHALL have port ALUOp, output, 1 bit: the ALU decoder selects the operation from Funct.
REQ-012 The block SHALL have port AdrSrc, output, 1 bit: memory address source, 0 = PC, 1 = ALU result register.
REQ-013 The block SHALL have ports ALUSrcA, ALUSrcB and ResultSrc, outputs, 2 bits each: datapath mux selects.
REQ-014 The block SHALL have port illegal, output, 1 bit: one-cycle pulse when an unimplemented Op is decoded.
REQ-015 The block SHALL have port state_o, output, 4 bits: current state encoding, for debug.

Function
REQ-016 The block SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB and BRANCH.
REQ-017 FETCH SHALL stay in FETCH while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-018 DECODE SHALL go to MEMADR on Op=01, to EXECI on Op=00 with Funct[5]=1, to EXECR on Op=00 with Funct[5]=0, to BRANCH on Op=10, and to FETCH on Op=11 with illegal=1 for that cycle.
REQ-019 MEMADR SHALL go to MEMRD when Funct[0]=1 and to MEMWR when Funct[0]=0.
REQ-020 MEMRD SHALL stay until mem_ready=1, then go to MEMWB.
REQ-021 MEMWR SHALL stay until mem_ready=1, then go to FETCH.
REQ-022 MEMWB, EXECR->ALUWB, EXECI->ALUWB, ALUWB->FETCH and BRANCH->FETCH SHALL each advance unconditionally after one cycle.
REQ-023 FETCH outputs SHALL be: mem_req=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, and IRWrite=NextPC=mem_ready.
REQ-024 DECODE outputs SHALL be: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
REQ-025 MEMADR and EXECI outputs SHALL be ALUSrcA=00 and ALUSrcB=01; EXECR outputs SHALL be ALUSrcA=00 and ALUSrcB=00.
REQ-026 ALUOp SHALL be 1 only in EXECR and EXECI.
REQ-027 MEMRD outputs SHALL be mem_req=1, AdrSrc=1, ResultSrc=00.
REQ-028 MEMWR outputs SHALL be mem_req=1, AdrSrc=1, MemW=mem_ready.
REQ-029 MEMWB outputs SHALL be ResultSrc=01, RegW=1; ALUWB outputs SHALL be ResultSrc=00, RegW=1.
REQ-030 BRANCH outputs SHALL be ALUSrcA=10, ALUSrcB=01, ResultSrc=10, Branch=1.
REQ-031 Any output not listed for a state SHALL be 0; no output SHALL be X in any state.
REQ-032 Every strobe (IRWrite, NextPC, RegW, MemW, Branch) SHALL be asserted for at most one clock edge per instruction.
REQ-033 Zero-wait latency SHALL be: B = 3 cycles, data-processing = 4, STR = 4, LDR = 5; each wait cycle adds exactly one cycle.
REQ-034 Op and Funct SHALL be sampled only in DECODE and MEMADR; their changes in other states SHALL have no effect.

Reset
REQ-035 While reset=0, the FSM SHALL hold FETCH asynchronously, and mem_req, IRWrite, NextPC, RegW, MemW, Branch, ALUOp and illegal SHALL all be 0.
REQ-036 Reset asserted mid-instruction, including while waiting in MEMRD or MEMWR, SHALL abort it with no strobe asserted.
REQ-037 The first rising edge after reset is released SHALL be evaluated in FETCH.

Structure
REQ-038 The state enum (4-bit encoding, FETCH=0) and the Op constants (OP_DP=00, OP_MEM=01, OP_B=10) SHALL reside in shared package mc_pkg.
REQ-039 The state-to-output decode SHALL be one combinational sub-module, mc_outdec; next-state logic and the state register SHALL remain in mc_mainfsm.

Verification
REQ-040 Scenario: Op=00, Funct=001000, mem_ready=1 -> states FETCH, DECODE, EXECR, ALUWB, FETCH; RegW=1 in cycle 4 only; ALUOp=1 in cycle 3 only.
REQ-041 Scenario: Op=01, Funct=011001, mem_ready=0 for 2 cycles in MEMRD -> MEMRD held 3 cycles, then MEMWB with RegW=1, ResultSrc=01; total 7 cycles.
REQ-042 Scenario: Op=01, Funct=011000, mem_ready low in MEMWR for 3 cycles -> MemW=0 during the wait, MemW=1 exactly on the ready cycle, then FETCH.
REQ-043 Scenario: Op=10 -> FETCH, DECODE, BRANCH; Branch=1 and ALUSrcA=10 for one cycle; back in FETCH on cycle 4.
REQ-044 Scenario: Op=11 -> illegal=1 for one cycle in DECODE, no strobes asserted, next state FETCH.
REQ-045 Scenario: reset driven low asynchronously mid-MEMWR with mem_ready=1 -> MemW drops to 0 immediately without waiting for a clock edge; state_o=0 until reset is released.
